// File: rtl/attack_sequencer.sv
// Attack frame sequencer: turns controller input into a timed attack word
// (startup -> active -> recovery) counted in game frames.
module attack_sequencer #(
  parameter int unsigned SMASH_STARTUP  = 6,
  parameter int unsigned SMASH_ACTIVE   = 3,
  parameter int unsigned SMASH_RECOVERY = 10,
  parameter int unsigned A_STARTUP      = 2,
  parameter int unsigned A_ACTIVE       = 2,
  parameter int unsigned A_RECOVERY     = 4,
  parameter int unsigned B_STARTUP      = 4,
  parameter int unsigned B_ACTIVE       = 4,
  parameter int unsigned B_RECOVERY     = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic        smash,
  input  logic        dir_up,
  input  logic        dir_down,
  input  logic        dir_left,
  input  logic        dir_right,
  input  logic        hitstun,
  output logic [31:0] attack,
  output logic        busy,
  output logic        attack_done
);

  typedef enum logic [1:0] {IDLE, STARTUP, ACTIVE, RECOVERY} state_t;
  typedef enum logic [1:0] {CLS_SMASH, CLS_A, CLS_B} class_t;

  state_t      state_q, state_n;
  logic [31:0] cnt_q, cnt_n;
  // type_q[k] corresponds to attack bit k+1
  logic [9:0]  type_q, type_n;
  logic        done_n;
  logic [9:0]  sel_type;
  class_t      sel_class;
  class_t      cur_class;
  logic        any_dir;

  // Reload value (length-1) for a given attack class and phase
  function automatic logic [31:0] phase_len(input class_t c, input state_t ph);
    logic [31:0] len;
    len = 32'd1;
    case (c)
      CLS_SMASH: case (ph)
        STARTUP:  len = 32'(SMASH_STARTUP);
        ACTIVE:   len = 32'(SMASH_ACTIVE);
        default:  len = 32'(SMASH_RECOVERY);
      endcase
      CLS_A: case (ph)
        STARTUP:  len = 32'(A_STARTUP);
        ACTIVE:   len = 32'(A_ACTIVE);
        default:  len = 32'(A_RECOVERY);
      endcase
      default: case (ph)
        STARTUP:  len = 32'(B_STARTUP);
        ACTIVE:   len = 32'(B_ACTIVE);
        default:  len = 32'(B_RECOVERY);
      endcase
    endcase
    return len - 32'd1;
  endfunction

  // Attack type selection from buttons and stick (A over B, up>down>left>right)
  always_comb begin
    sel_type  = '0;
    sel_class = CLS_B;
    any_dir   = dir_up | dir_down | dir_left | dir_right;
    if (btn_a) begin
      if (smash && any_dir) begin
        sel_class = CLS_SMASH;
        if (dir_up)        sel_type[0] = 1'b1;
        else if (dir_down) sel_type[1] = 1'b1;
        else if (dir_left) sel_type[2] = 1'b1;
        else               sel_type[3] = 1'b1;
      end else begin
        sel_class   = CLS_A;
        sel_type[4] = 1'b1;
      end
    end else if (btn_b) begin
      sel_class = CLS_B;
      if (dir_up)         sel_type[5] = 1'b1;
      else if (dir_down)  sel_type[6] = 1'b1;
      else if (dir_left)  sel_type[7] = 1'b1;
      else if (dir_right) sel_type[8] = 1'b1;
      else                sel_type[9] = 1'b1;
    end
  end

  // Class of the attack in progress, recovered from the latched type bits
  always_comb begin
    if (|type_q[3:0])   cur_class = CLS_SMASH;
    else if (type_q[4]) cur_class = CLS_A;
    else                cur_class = CLS_B;
  end

  // Next-state, counter and type logic; hitstun beats frame advancement
  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    type_n  = type_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_tick && !hitstun && (btn_a || btn_b)) begin
          state_n = STARTUP;
          type_n  = sel_type;
          cnt_n   = phase_len(sel_class, STARTUP);
        end
      end
      default: begin
        if (hitstun) begin
          state_n = IDLE;
          cnt_n   = '0;
          type_n  = '0;
        end else if (frame_tick) begin
          if (cnt_q == '0) begin
            case (state_q)
              STARTUP: begin
                state_n = ACTIVE;
                cnt_n   = phase_len(cur_class, ACTIVE);
              end
              ACTIVE: begin
                state_n = RECOVERY;
                cnt_n   = phase_len(cur_class, RECOVERY);
              end
              default: begin
                state_n = IDLE;
                cnt_n   = '0;
                type_n  = '0;
                done_n  = 1'b1;
              end
            endcase
          end else begin
            cnt_n = cnt_q - 32'd1;
          end
        end
      end
    endcase
  end

  // State register; outputs are registered from the next-state values
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      type_q      <= '0;
      attack      <= '0;
      busy        <= 1'b0;
      attack_done <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      type_q      <= type_n;
      attack      <= {21'd0, type_n, (state_n == ACTIVE)};
      busy        <= (state_n != IDLE);
      attack_done <= done_n;
    end
  end

endmodule

// File: tb/tb_attack_sequencer.sv
// Scoreboard bench for attack_sequencer: a per-attack frame plan model
// predicts outputs, a monitor compares every cycle.
module tb_attack_sequencer;

  localparam int unsigned SS = 6, SA = 3, SR = 10;
  localparam int unsigned AS = 2, AA = 2, AR = 4;
  localparam int unsigned BS = 4, BA = 4, BR = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        frame_tick = 1'b0;
  logic        btn_a = 1'b0, btn_b = 1'b0, smash = 1'b0;
  logic        dir_up = 1'b0, dir_down = 1'b0, dir_left = 1'b0, dir_right = 1'b0;
  logic        hitstun = 1'b0;
  logic [31:0] attack;
  logic        busy;
  logic        attack_done;

  always #5 clock = ~clock;

  attack_sequencer #(
    .SMASH_STARTUP(SS), .SMASH_ACTIVE(SA), .SMASH_RECOVERY(SR),
    .A_STARTUP(AS), .A_ACTIVE(AA), .A_RECOVERY(AR),
    .B_STARTUP(BS), .B_ACTIVE(BA), .B_RECOVERY(BR)
  ) dut (
    .clock(clock), .reset(reset), .frame_tick(frame_tick),
    .btn_a(btn_a), .btn_b(btn_b), .smash(smash),
    .dir_up(dir_up), .dir_down(dir_down), .dir_left(dir_left), .dir_right(dir_right),
    .hitstun(hitstun), .attack(attack), .busy(busy), .attack_done(attack_done)
  );

  typedef struct packed {
    logic [31:0] attack;
    logic        busy;
    logic        done;
    logic [31:0] cyc;
  } exp_t;

  exp_t        expq[$];
  int unsigned tests = 0;
  int unsigned fails = 0;
  int unsigned cyc = 0;

  // Reference model: remaining per-tick attack words of the current attack
  logic [31:0] plan[$];
  logic [31:0] cur = '0;
  logic        mdone = 1'b0;

  function automatic logic [31:0] pick_type(input logic a, b, s, u, d, l, r);
    if (a) begin
      if (s && (u || d || l || r)) begin
        if (u) return 32'h2;
        if (d) return 32'h4;
        if (l) return 32'h8;
        return 32'h10;
      end
      return 32'h20;
    end
    if (b) begin
      if (u) return 32'h40;
      if (d) return 32'h80;
      if (l) return 32'h100;
      if (r) return 32'h200;
      return 32'h400;
    end
    return 32'h0;
  endfunction

  task automatic build_plan(input logic [31:0] t);
    int unsigned st, ac, rc;
    if (t <= 32'h10)      begin st = SS; ac = SA; rc = SR; end
    else if (t == 32'h20) begin st = AS; ac = AA; rc = AR; end
    else                  begin st = BS; ac = BA; rc = BR; end
    plan.delete();
    for (int unsigned i = 1; i < st; i++) plan.push_back(t);
    for (int unsigned i = 0; i < ac; i++) plan.push_back(t | 32'h1);
    for (int unsigned i = 0; i < rc; i++) plan.push_back(t);
    plan.push_back(32'h0);
  endtask

  // Apply the model for the current inputs, queue the expectation, run one clock
  task automatic drive();
    exp_t e;
    logic [31:0] t;
    if (reset) begin
      plan.delete(); cur = '0; mdone = 1'b0;
    end else if (plan.size() != 0) begin
      mdone = 1'b0;
      if (hitstun) begin
        plan.delete(); cur = '0;
      end else if (frame_tick) begin
        cur   = plan.pop_front();
        mdone = (plan.size() == 0);
      end
    end else begin
      mdone = 1'b0;
      if (frame_tick && !hitstun && (btn_a || btn_b)) begin
        t   = pick_type(btn_a, btn_b, smash, dir_up, dir_down, dir_left, dir_right);
        cur = t;
        build_plan(t);
      end
    end
    e.attack = cur;
    e.busy   = (plan.size() != 0);
    e.done   = mdone;
    e.cyc    = cyc;
    expq.push_back(e);
    cyc++;
    @(posedge clock);
    #2;
  endtask

  task automatic set_in(input logic a, b, s, u, d, l, r);
    btn_a = a; btn_b = b; smash = s;
    dir_up = u; dir_down = d; dir_left = l; dir_right = r;
  endtask

  task automatic ticks(input int unsigned n, input int unsigned gap);
    for (int unsigned i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      drive();
      frame_tick = 1'b0;
      for (int unsigned g = 0; g < gap; g++) drive();
    end
  endtask

  // Monitor: compare registered outputs just after each edge
  always @(posedge clock) begin
    exp_t e;
    #1;
    if (expq.size() != 0) begin
      e = expq.pop_front();
      tests++;
      if (attack !== e.attack) begin
        fails++;
        $display("FAIL attack cyc %0d: got %h expected %h", e.cyc, attack, e.attack);
      end
      tests++;
      if (busy !== e.busy) begin
        fails++;
        $display("FAIL busy cyc %0d: got %b expected %b", e.cyc, busy, e.busy);
      end
      tests++;
      if (attack_done !== e.done) begin
        fails++;
        $display("FAIL attack_done cyc %0d: got %b expected %b", e.cyc, attack_done, e.done);
      end
    end
  end

  initial begin
    @(posedge clock);
    #2;
    reset = 1'b1;
    repeat (3) drive();
    reset = 1'b0;

    // Up smash with defaults
    set_in(1, 0, 1, 1, 0, 0, 0); ticks(1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); ticks(19, 0);
    drive();

    // A and B together, no direction: neutral A, buttons held through return
    set_in(1, 1, 0, 0, 0, 0, 0); ticks(1, 0);
    ticks(8, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); ticks(10, 0);

    // Side B left, inputs changed mid-attack
    set_in(0, 1, 0, 0, 0, 1, 1); ticks(1, 0);
    set_in(1, 0, 1, 1, 0, 0, 0); ticks(16, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); ticks(1, 0);

    // Side smash right interrupted by hitstun during ACTIVE, then neutral B
    set_in(1, 0, 1, 0, 0, 0, 1); ticks(1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); ticks(7, 0);
    hitstun = 1'b1; frame_tick = 1'b1; drive();
    hitstun = 1'b0; frame_tick = 1'b0; drive(); drive();
    set_in(0, 1, 0, 0, 0, 0, 0); ticks(1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); ticks(20, 0);

    // Hitstun in IDLE blocks a start
    set_in(1, 0, 0, 0, 0, 0, 0); hitstun = 1'b1; ticks(1, 0);
    hitstun = 1'b0; set_in(0, 0, 0, 0, 0, 0, 0); ticks(1, 0);

    // Reset in RECOVERY with frame_tick high, then immediate restart
    set_in(1, 0, 0, 0, 0, 0, 0); ticks(1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); ticks(5, 0);
    reset = 1'b1; frame_tick = 1'b1; btn_a = 1'b1; drive();
    reset = 1'b0; frame_tick = 1'b0; drive();
    ticks(1, 0);
    btn_a = 1'b0; ticks(10, 0);

    // Idle gaps of 5 cycles between ticks
    set_in(1, 0, 1, 0, 1, 0, 0); ticks(1, 5);
    set_in(0, 0, 0, 0, 0, 0, 0); ticks(20, 5);
    set_in(0, 1, 0, 1, 0, 0, 0); ticks(1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0); ticks(17, 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      frame_tick = ($urandom_range(0, 2) == 0);
      btn_a      = ($urandom_range(0, 3) == 0);
      btn_b      = ($urandom_range(0, 3) == 0);
      smash      = $urandom_range(0, 1) == 1;
      dir_up     = ($urandom_range(0, 3) == 0);
      dir_down   = ($urandom_range(0, 3) == 0);
      dir_left   = ($urandom_range(0, 3) == 0);
      dir_right  = ($urandom_range(0, 3) == 0);
      hitstun    = ($urandom_range(0, 59) == 0);
      reset      = ($urandom_range(0, 299) == 0);
      drive();
    end
    reset = 1'b0; hitstun = 1'b0; frame_tick = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0);
    drive();

    @(posedge clock);
    #2;
    tests++;
    if (expq.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/attack_sequencer.md
ATTACK_SEQUENCER -- requirements
Module: attack_sequencer

Interface
REQ-001 Parameter SMASH_STARTUP, default 6: startup frames for up/down/side smash.
REQ-002 Parameter SMASH_ACTIVE, default 3: active frames for smashes.
REQ-003 Parameter SMASH_RECOVERY, default 10: recovery frames for smashes.
REQ-004 Parameter A_STARTUP / A_ACTIVE / A_RECOVERY, defaults 2 / 2 / 4: frame counts for the neutral A attack.
REQ-005 Parameter B_STARTUP / B_ACTIVE / B_RECOVERY, defaults 4 / 4 / 8: frame counts for all B attacks (neutral, up, down, side).
REQ-006 All frame-count parameters SHALL be ≥1; values of 0 are unsupported.
REQ-007 reset is synchronous and active-high; clock is clock; every register updates on the rising edge of clock.
REQ-008 clock  input  1  system clock.
REQ-009 reset  input  1  synchronous active-high reset.
REQ-010 frame_tick  input  1  one-cycle pulse per game frame.
REQ-011 btn_a, btn_b, smash  input  1 each  controller A, B, and smash modifier, level-sensitive.
REQ-012 dir_up, dir_down, dir_left, dir_right  input  1 each  stick direction, level-sensitive.
REQ-013 hitstun  input  1  player was hit; aborts any attack.
REQ-014 attack  output  32  attack word for the damage coprocessor, registered.
REQ-015 busy  output  1  high in any state other than IDLE, registered.
REQ-016 attack_done  output  1  one-cycle pulse on normal completion, registered.

Function
REQ-017 The FSM SHALL have four states: IDLE, STARTUP, ACTIVE, RECOVERY.
REQ-018 Attack word encoding: bit0 = hitbox live; bit1 up smash; bit2 down smash; bit3 side smash left; bit4 side smash right; bit5 A; bit6 up B; bit7 down B; bit8 side B left; bit9 side B right; bit10 B; bits 31:11 always 0.
REQ-019 Start condition: state IDLE, frame_tick=1, hitstun=0, and (btn_a|btn_b)=1.
REQ-020 Type selection at start: btn_a has priority over btn_b; direction priority is up > down > left > right > none.
REQ-021 btn_a with smash=1 and a direction selects the matching smash bit (1/2/3/4); btn_a with smash=0, or with no direction, selects bit5.
REQ-022 btn_b selects bit6/7/8/9 by direction, or bit10 with no direction; smash is ignored for B.
REQ-023 On the start edge: state becomes STARTUP; exactly one type bit is set; bit0=0; busy=1; the frame counter loads STARTUP-1 for the selected class.
REQ-024 In STARTUP/ACTIVE/RECOVERY, on each frame_tick: if counter=0, advance to the next phase and load that phase's count-1; otherwise decrement. Cycles without frame_tick SHALL hold all state.
REQ-025 Each phase SHALL therefore last exactly its parameter value of frame_ticks.
REQ-026 attack[0] SHALL be 1 exactly while in ACTIVE; the type bit SHALL be held constant from STARTUP through RECOVERY.
REQ-027 Exit RECOVERY (counter=0 and frame_tick): next state IDLE, attack=0, busy=0, attack_done=1 for that one cycle.
REQ-028 A new attack SHALL NOT start on the same edge as the return to IDLE; the earliest restart is the next frame_tick.
REQ-029 Buttons and directions SHALL be ignored while busy; there is no input buffering.
REQ-030 hitstun=1 in any non-IDLE state SHALL force IDLE, attack=0, busy=0 on the next edge, with attack_done=0; hitstun takes priority over frame_tick advancement.
REQ-031 hitstun=1 in IDLE SHALL block starts.
REQ-032 attack_done SHALL be 0 on every cycle except the one specified in REQ-027.

Reset
REQ-033 reset=1 SHALL force IDLE, counter=0, attack=0, busy=0, attack_done=0 on the next edge, overriding all other inputs, including mid-attack.
REQ-034 The first start SHALL be possible on the first frame_tick after reset is deasserted.

Verification
REQ-035 Defaults: btn_a=1, smash=1, dir_up=1 on a tick -> attack=0x2 for 6 ticks, then 0x3 for 3 ticks, then 0x2 for 10 ticks, then 0 with a single attack_done pulse.
REQ-036 btn_a=1 and btn_b=1, no direction -> attack=0x20; bit0 is high for exactly ticks 3-4; busy falls after 8 ticks total.
REQ-037 btn_b=1, dir_left=1, dir_right=1 -> attack=0x100 held; buttons changed mid-attack -> no change to attack.
REQ-038 hitstun pulsed during ACTIVE of a side smash right (0x11) -> attack=0 on the next edge; no attack_done; a new btn_b on a later tick -> 0x400.
REQ-039 reset asserted mid-RECOVERY with frame_tick held high -> all outputs 0 on the next edge; after release, the first tick with btn_a=1 starts an attack.
REQ-040 Gaps of 0 and 5 idle cycles between frame_ticks -> phase lengths are counted in ticks only and are unchanged.
